// File: rtl/image_mem_pkg.sv
// rtl/image_mem_pkg.sv - shared frame geometry, address width and clear FSM states
package image_mem_pkg;

    localparam int IMG_W      = 240;
    localparam int IMG_PIXELS = IMG_W * IMG_W;
    localparam int IMG_ADDR_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/image_wr_fifo.sv
// rtl/image_wr_fifo.sv - small synchronous FIFO holding pending {addr, data} pixel writes
module image_wr_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [ADDR_W+DATA_W-1:0] din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [ADDR_W+DATA_W-1:0] head
);

    localparam int ENT_W = ADDR_W + DATA_W;
    // DEPTH is a power of two, so the pointers wrap naturally
    localparam int PTR_W = $clog2(DEPTH);

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W:0]   count_q;

    assign full  = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Entry storage; no reset needed because the pointers define which slots are live
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; a pop on an empty FIFO is only issued together
    // with a push, which then passes straight through
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/image_mem_arbiter.sv
// rtl/image_mem_arbiter.sv - frame BRAM arbiter: display reads, frame clear (IMAGE_MEM_CLEAR_EN), queued pixel writes
module image_mem_arbiter
    import image_mem_pkg::*;
#(
    parameter int ADDR_W     = IMG_ADDR_W,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              wr_err,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int ENT_W = ADDR_W + DATA_W;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  fifo_head;
    logic [ENT_W-1:0]  head;
    logic              head_valid;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              head_in_range;
    logic              clr_active;
    logic              clr_grant;
    logic              fifo_grant;
    logic [ADDR_W-1:0] clr_ptr;

    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] mem_din_q;
    logic              rd_v1_q;
    logic              rd_v2_q;
    logic              wr_err_q;

    assign wr_ready = !fifo_full;
    assign push     = wr_req && !fifo_full;

    image_wr_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   ({wr_addr, wr_data}),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // An empty FIFO forwards the incoming push, so an uncontended write lands one cycle after it is offered
    assign head          = fifo_empty ? {wr_addr, wr_data} : fifo_head;
    assign head_valid    = !fifo_empty || push;
    assign head_addr     = head[ENT_W-1:DATA_W];
    assign head_data     = head[DATA_W-1:0];
    assign head_in_range = (32'(head_addr) < IMG_PIXELS);

`ifdef IMAGE_MEM_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_PIXELS - 1);

    clr_state_t        state_q;
    logic [ADDR_W-1:0] clr_ptr_q;

    assign clr_active = (state_q == CLEAR);
    assign clr_ptr    = clr_ptr_q;

    // Clear FSM: walks the frame one pixel per non-display cycle, never skipping an address
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            clr_ptr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clear_start) begin
                        state_q   <= CLEAR;
                        clr_ptr_q <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_grant) begin
                        clr_ptr_q <= clr_ptr_q + 1'b1;
                        if (clr_ptr_q == LAST_PIX) begin
                            state_q <= IDLE;
                        end
                    end
                end
            endcase
        end
    end
`else
    logic unused_clear_start;

    assign unused_clear_start = clear_start;
    assign clr_active         = 1'b0;
    assign clr_ptr            = '0;
`endif

    assign clear_busy = clr_active;
    assign clr_grant  = clr_active && !disp_req;
    assign fifo_grant = !disp_req && !clr_active && head_valid;
    assign pop        = fifo_grant;

    // Register the winning access onto the BRAM port and pipeline the display read valid
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
            mem_din_q  <= '0;
            rd_v1_q    <= 1'b0;
            rd_v2_q    <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            rd_v1_q  <= disp_req;
            rd_v2_q  <= rd_v1_q;
            if (disp_req) begin
                mem_addr_q <= disp_addr;
            end else if (clr_grant) begin
                mem_addr_q <= clr_ptr;
                mem_din_q  <= '0;
                mem_we_q   <= 1'b1;
            end else if (fifo_grant) begin
                if (head_in_range) begin
                    mem_addr_q <= head_addr;
                    mem_din_q  <= head_data;
                    mem_we_q   <= 1'b1;
                end else begin
                    wr_err_q <= 1'b1;
                end
            end
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_din    = mem_din_q;
    assign disp_valid = rd_v2_q;
    assign disp_data  = mem_dout;
    assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_image_mem_arbiter.sv
// tb/tb_image_mem_arbiter.sv - self-checking bench for image_mem_arbiter
module tb_image_mem_arbiter;

    localparam int DEPTH  = 4;
    localparam int PIXELS = 57600;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        disp_req;
    logic [15:0] disp_addr;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        wr_err;
    logic        clear_start;
    logic        clear_busy;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;

    int checks = 0;
    int errors = 0;

    logic [7:0] bram    [0:65535];
    logic [7:0] exp_mem [0:63];

    image_mem_arbiter #(
        .ADDR_W     (16),
        .DATA_W     (8),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_data   (disp_data),
        .disp_valid  (disp_valid),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .wr_err      (wr_err),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) bram[mem_addr] <= mem_din;
        mem_dout <= bram[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; disp_req = 1'b0; disp_addr = '0; wr_req = 1'b0;
        wr_addr = '0; wr_data = '0; clear_start = 1'b0;
        tick(); tick();
        reset = 1'b0;
        checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem_addr got %h expected 0000", mem_addr); end
        checks++; if (mem_din !== 8'h0) begin errors++; $display("FAIL reset_mem_din got %h expected 00", mem_din); end
        checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err got %b expected 0", wr_err); end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we cycle %0d got %b expected 0", i, mem_we); end
            checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready cycle %0d got %b expected 1", i, wr_ready); end
            checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL reset_clear_busy cycle %0d got %b expected 0", i, clear_busy); end
            checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset_disp_valid cycle %0d got %b expected 0", i, disp_valid); end
        end
    endtask

    task automatic test_display_read();
        disp_req = 1'b0; wr_req = 1'b1; wr_addr = 16'h1234; wr_data = 8'h5A;
        tick();
        checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h1234 || mem_din !== 8'h5A) begin
            errors++; $display("FAIL preload_write got we=%b addr=%h din=%h expected we=1 addr=1234 din=5a", mem_we, mem_addr, mem_din); end
        wr_addr = 16'h0100; wr_data = 8'h11;
        tick();
        checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h0100) begin
            errors++; $display("FAIL second_write got we=%b addr=%h expected we=1 addr=0100", mem_we, mem_addr); end
        wr_req = 1'b0; disp_req = 1'b1; disp_addr = 16'h1234;
        tick();
        checks++; if (mem_addr !== 16'h1234 || mem_we !== 1'b0) begin
            errors++; $display("FAIL disp_addr_n1 got addr=%h we=%b expected addr=1234 we=0", mem_addr, mem_we); end
        checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL disp_valid_n1 got %b expected 0", disp_valid); end
        disp_req = 1'b0;
        tick();
        checks++; if (disp_valid !== 1'b1 || disp_data !== 8'h5A) begin
            errors++; $display("FAIL disp_data_n2 got valid=%b data=%h expected valid=1 data=5a", disp_valid, disp_data); end
        tick();
        checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL disp_valid_n3 got %b expected 0", disp_valid); end
    endtask

    task automatic test_fifo_drain();
        disp_req = 1'b1; disp_addr = 16'h0020;
        for (int i = 0; i < 4; i++) begin
            wr_req = 1'b1; wr_addr = 16'(10 + i); wr_data = 8'(1 + i);
            checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL drain_ready_before_push %0d got %b expected 1", i, wr_ready); end
            tick();
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL drain_no_we_while_disp %0d got %b expected 0", i, mem_we); end
        end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL drain_full got wr_ready=%b expected 0", wr_ready); end
        wr_addr = 16'd99; wr_data = 8'hFF;
        tick();
        checks++; if (wr_ready !== 1'b0 || mem_we !== 1'b0) begin
            errors++; $display("FAIL drain_ignored_push got ready=%b we=%b expected 0 0", wr_ready, mem_we); end
        wr_req = 1'b0; disp_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (mem_we !== 1'b1 || mem_addr !== 16'(10 + i) || mem_din !== 8'(1 + i)) begin
                errors++; $display("FAIL drain_order %0d got we=%b addr=%0d din=%0d expected we=1 addr=%0d din=%0d",
                                   i, mem_we, mem_addr, mem_din, 10 + i, 1 + i); end
            checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL drain_ready_after_pop %0d got %b expected 1", i, wr_ready); end
        end
        tick();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL drain_empty_idle got we=%b expected 0", mem_we); end
    endtask

    task automatic test_out_of_range();
        disp_req = 1'b0; wr_req = 1'b1; wr_addr = 16'd57600; wr_data = 8'hEE;
        tick();
        checks++; if (mem_we !== 1'b0 || wr_err !== 1'b1) begin
            errors++; $display("FAIL oor_drop got we=%b err=%b expected we=0 err=1", mem_we, wr_err); end
        checks++; if (mem_addr !== 16'd13) begin errors++; $display("FAIL oor_addr_hold got %0d expected 13", mem_addr); end
        wr_addr = 16'd20; wr_data = 8'h77;
        tick();
        checks++; if (mem_we !== 1'b1 || mem_addr !== 16'd20 || mem_din !== 8'h77) begin
            errors++; $display("FAIL oor_next_write got we=%b addr=%0d din=%h expected we=1 addr=20 din=77", mem_we, mem_addr, mem_din); end
        wr_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL oor_sticky %0d got %b expected 1", i, wr_err); end
        end
    endtask

    task automatic test_back_to_back();
        disp_req = 1'b0;
        for (int i = 0; i < 64; i++) begin
            wr_req = 1'b1; wr_addr = 16'(i); wr_data = 8'($urandom);
            exp_mem[i] = wr_data;
            tick();
            checks++; if (mem_we !== 1'b1 || mem_addr !== 16'(i) || mem_din !== exp_mem[i]) begin
                errors++; $display("FAIL b2b_write %0d got we=%b addr=%0d din=%h expected we=1 addr=%0d din=%h",
                                   i, mem_we, mem_addr, mem_din, i, exp_mem[i]); end
        end
        wr_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        ent_t        q[$];
        ent_t        e;
        logic [15:0] last_addr = 16'h0;
        logic        exp_err = 1'b0;
        logic        exp_ready;
        logic        exp_we;
        logic [7:0]  exp_din = 8'h0;
        logic        hold = 1'b0;
        logic        prev_rd = 1'b0;
        logic [7:0]  prev_rd_data = 8'h0;
        logic        cur_rd;
        logic [7:0]  cur_rd_data = 8'h0;
        reset = 1'b1; disp_req = 1'b0; wr_req = 1'b0;
        tick();
        reset = 1'b0;
        checks++; if (wr_err !== 1'b0 || mem_addr !== 16'h0) begin
            errors++; $display("FAIL rand_reset got err=%b addr=%h expected err=0 addr=0000", wr_err, mem_addr); end
        for (int k = 0; k < 3000; k++) begin
            disp_req  = ($urandom_range(0, 99) < 35);
            disp_addr = 16'($urandom_range(0, 63));
            if (!hold) begin
                wr_req = ($urandom_range(0, 99) < 60);
                if ($urandom_range(0, 9) == 0) wr_addr = 16'($urandom_range(PIXELS, 65535));
                else wr_addr = 16'($urandom_range(0, 63));
                wr_data = 8'($urandom);
            end
            exp_ready = (q.size() < DEPTH);
            checks++; if (wr_ready !== exp_ready) begin
                errors++; $display("FAIL rand_wr_ready cyc %0d got %b expected %b", k, wr_ready, exp_ready); end
            if (wr_req && exp_ready) q.push_back('{a: wr_addr, d: wr_data});
            hold   = wr_req && !exp_ready;
            exp_we = 1'b0;
            cur_rd = disp_req;
            if (disp_req) begin
                last_addr   = disp_addr;
                cur_rd_data = exp_mem[disp_addr[5:0]];
            end else if (q.size() > 0) begin
                e = q.pop_front();
                if (32'(e.a) < PIXELS) begin
                    exp_we    = 1'b1;
                    last_addr = e.a;
                    exp_din   = e.d;
                    exp_mem[e.a[5:0]] = e.d;
                end else begin
                    exp_err = 1'b1;
                end
            end
            tick();
            checks++; if (mem_we !== exp_we || mem_addr !== last_addr) begin
                errors++; $display("FAIL rand_mem_port cyc %0d got we=%b addr=%h expected we=%b addr=%h", k, mem_we, mem_addr, exp_we, last_addr); end
            if (exp_we) begin
                checks++; if (mem_din !== exp_din) begin
                    errors++; $display("FAIL rand_mem_din cyc %0d got %h expected %h", k, mem_din, exp_din); end
            end
            checks++; if (wr_err !== exp_err) begin
                errors++; $display("FAIL rand_wr_err cyc %0d got %b expected %b", k, wr_err, exp_err); end
            checks++; if (disp_valid !== prev_rd) begin
                errors++; $display("FAIL rand_disp_valid cyc %0d got %b expected %b", k, disp_valid, prev_rd); end
            if (prev_rd) begin
                checks++; if (disp_data !== prev_rd_data) begin
                    errors++; $display("FAIL rand_disp_data cyc %0d got %h expected %h", k, disp_data, prev_rd_data); end
            end
            prev_rd      = cur_rd;
            prev_rd_data = cur_rd_data;
        end
        disp_req = 1'b0; wr_req = 1'b0;
        for (int i = 0; i < 6; i++) tick();
    endtask

`ifdef IMAGE_MEM_CLEAR_EN
    task automatic test_full_clear();
        int   exp_ptr = 0;
        int   busy = 0;
        int   ndisp = 0;
        int   bad = 0;
        int   k = 0;
        logic done = 1'b0;
        logic fell_ok = 1'b0;
        logic prev_disp = 1'b0;
        disp_req = 1'b0; wr_req = 1'b0; clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        checks++; if (clear_busy !== 1'b1) begin errors++; $display("FAIL clear_busy_rise got %b expected 1", clear_busy); end
        while (!done && k < 70000) begin
            disp_req    = (k < 4000) ? 1'($urandom_range(0, 1)) : 1'b0;
            disp_addr   = 16'($urandom_range(0, 63));
            wr_req      = (k == 5);
            wr_addr     = 16'd30;
            wr_data     = 8'hC3;
            clear_start = (k == 7);
            if (clear_busy === 1'b1) begin
                busy++;
                if (disp_req) ndisp++;
            end
            prev_disp = disp_req;
            tick();
            if (mem_we === 1'b1) begin
                if (prev_disp || mem_addr !== 16'(exp_ptr) || mem_din !== 8'h0) bad++;
                exp_ptr++;
                if (exp_ptr == PIXELS) begin
                    done    = 1'b1;
                    fell_ok = (clear_busy === 1'b0);
                end
            end
            k++;
        end
        wr_req = 1'b0; clear_start = 1'b0; disp_req = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL clear_timeout wrote %0d addresses expected %0d", exp_ptr, PIXELS); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL clear_sequence got %0d bad writes expected 0", bad); end
        checks++; if (busy !== PIXELS + ndisp) begin
            errors++; $display("FAIL clear_busy_cycles got %0d expected %0d", busy, PIXELS + ndisp); end
        checks++; if (fell_ok !== 1'b1) begin errors++; $display("FAIL clear_busy_fall got %b expected 1", fell_ok); end
        tick();
        checks++; if (mem_we !== 1'b1 || mem_addr !== 16'd30 || mem_din !== 8'hC3) begin
            errors++; $display("FAIL clear_queued_write got we=%b addr=%0d din=%h expected we=1 addr=30 din=c3", mem_we, mem_addr, mem_din); end
        tick();
        checks++; if (mem_we !== 1'b0 || clear_busy !== 1'b0) begin
            errors++; $display("FAIL clear_after got we=%b busy=%b expected 0 0", mem_we, clear_busy); end
    endtask

    task automatic test_reset_mid_clear();
        int   k = 0;
        logic reached = 1'b0;
        disp_req = 1'b0; wr_req = 1'b0; clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        while (!reached && k < 3000) begin
            wr_req  = (k == 1 || k == 2);
            wr_addr = 16'(40 + k);
            wr_data = 8'h99;
            tick();
            k++;
            if (mem_we === 1'b1 && mem_addr === 16'd999) reached = 1'b1;
        end
        wr_req = 1'b0;
        checks++; if (reached !== 1'b1 || clear_busy !== 1'b1) begin
            errors++; $display("FAIL midclr_reach got reached=%b busy=%b expected 1 1", reached, clear_busy); end
        reset = 1'b1;
        tick();
        checks++; if (clear_busy !== 1'b0 || wr_ready !== 1'b1 || mem_we !== 1'b0) begin
            errors++; $display("FAIL midclr_reset got busy=%b ready=%b we=%b expected 0 1 0", clear_busy, wr_ready, mem_we); end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (mem_we !== 1'b0 || clear_busy !== 1'b0) begin
                errors++; $display("FAIL midclr_quiet %0d got we=%b busy=%b expected 0 0", i, mem_we, clear_busy); end
        end
    endtask
`else
    task automatic test_clear_disabled();
        disp_req = 1'b0; wr_req = 1'b0; clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (clear_busy !== 1'b0 || mem_we !== 1'b0) begin
                errors++; $display("FAIL clear_ignored %0d got busy=%b we=%b expected 0 0", i, clear_busy, mem_we); end
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_display_read();
        test_fifo_drain();
        test_out_of_range();
        test_back_to_back();
        test_random();
`ifdef IMAGE_MEM_CLEAR_EN
        test_full_clear();
        test_reset_mid_clear();
`else
        test_clear_disabled();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/image_mem_arbiter.md
# image_mem_arbiter

Arbiter and sequencer for the single-port 240x240 image frame BRAM. The VGA display path issues read addresses from the image address generator; a pixel writer, such as the game renderer, pushes writes through a small FIFO. An optional clear engine zeroes the whole frame. The block sits between these requesters and the BRAM, gives display reads absolute priority, and sequences all other accesses into cycles the display does not use.

## Interface
- `ADDR_W`, default 16: image memory address width.
- `DATA_W`, default 8: pixel width.
- `FIFO_DEPTH`, default 4: write FIFO entries; must be a power of two.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `disp_req` in 1: display read request this cycle; high while hcount<480 and vcount<480.
- `disp_addr` in ADDR_W: display read address.
- `disp_data` out DATA_W: read data, driven from `mem_dout`.
- `disp_valid` out 1: `disp_data` is valid this cycle.
- `wr_req` in 1: write push request.
- `wr_addr` in ADDR_W: write address.
- `wr_data` in DATA_W: write data.
- `wr_ready` out 1: FIFO not full.
- `wr_err` out 1: sticky flag; an out-of-range write was dropped.
- `clear_start` in 1: one-cycle pulse that starts a frame clear.
- `clear_busy` out 1: clear in progress.
- `mem_addr` out ADDR_W: registered BRAM address.
- `mem_we` out 1: registered BRAM write enable.
- `mem_din` out DATA_W: registered BRAM write data.
- `mem_dout` in DATA_W: BRAM read data, 1-cycle read latency.

## Operation
- **Per-cycle grant**, strict priority, one grant per cycle:
  - `disp_req`, then clear engine, then FIFO head.
  - Granted access is registered onto `mem_*` the next cycle.
  - Idle cycle: `mem_we`=0 and `mem_addr` holds its previous value.
- **Display grant:** `mem_we`=0, `mem_addr`=`disp_addr`. A 2-stage valid pipeline asserts `disp_valid`.
- **Write FIFO:**
  - Push when `wr_req`&&`wr_ready`.
  - Pop only on a FIFO grant.
  - Push and pop in the same cycle are legal; occupancy is unchanged.
  - `wr_ready` reflects full status at the start of the cycle.
  - `wr_req` while `wr_ready`=0 is ignored; the requester must hold.
- **Range check** at pop:
  - An entry with address ≥ 57600 is popped and discarded (`mem_we` stays 0).
  - The discard sets `wr_err`, which stays set until reset.
- **Clear FSM** (`IDLE`, `CLEAR`):
  - `IDLE` to `CLEAR` on `clear_start`; the pointer loads 0.
  - In `CLEAR`, each clear grant writes 0 to the pointer address and then increments the pointer.
  - After the grant at address 57599, return to `IDLE`.
  - `clear_busy`=1 exactly while in `CLEAR`.
  - `clear_start` while in `CLEAR` is ignored.
  - The FIFO keeps accepting pushes during `CLEAR` until full; entries drain only after the clear completes.
- **Mid-operation reset:** returns to `IDLE`, empties the FIFO, zeroes the pipeline, and clears `wr_err`.
- **Reset values:** `mem_we`=0, `mem_addr`=0, `mem_din`=0, `disp_valid`=0, `wr_ready`=1, `wr_err`=0, `clear_busy`=0.

## Timing
- **Display read:** `disp_req` sampled at edge N, `mem_addr` valid in cycle N+1, `disp_valid`=1 with data in cycle N+2. Throughput is one read per cycle.
- **FIFO write:** push at edge N, earliest `mem_we` in cycle N+1 if there is no contention.
- **Back-to-back drain:** one FIFO write per idle cycle, in push order.
- **Full clear:** takes exactly 57600 non-display cycles, plus one cycle for the `IDLE`→`CLEAR` transition. Display cycles stall the clear and do not skip addresses.
- **`clear_busy`:** rises in the cycle after `clear_start`. It falls in the cycle after the final clear grant, which is the same cycle the final write appears on `mem_*`.

## Configuration
- `IMAGE_MEM_CLEAR_EN` defined: the clear engine and FSM are built as specified.
- Undefined:
  - `clear_start` is ignored and `clear_busy` is tied to 0.
  - The priority is display, then FIFO.
  - All other behaviour is unchanged.

## Structure
- Package `image_mem_pkg`:
  - `IMG_W`=240 and `IMG_PIXELS`=57600.
  - `ADDR_W` default.
  - Clear FSM state enum (`IDLE`, `CLEAR`).
- Sub-module `image_wr_fifo`: synchronous FIFO, parameters DATA and ADDR width plus depth. Ports: push, pop, full, empty, head.
- The arbiter holds the grant mux, the output registers, the valid pipeline and the clear FSM.

## Test plan
- **Reset idle:** reset, then 10 idle cycles → `mem_we`=0, `wr_ready`=1, `clear_busy`=0, `disp_valid`=0 throughout.
- **Display read:** `disp_req` at edge N with `disp_addr`=0x1234 and BRAM preloaded with 0x5A → `mem_addr`=0x1234 in N+1; `disp_valid`=1 and `disp_data`=0x5A in N+2.
- **FIFO drain:** hold `disp_req`=1 and push 4 writes (addr 10..13, data 1..4) → `wr_ready`=0 after the 4th push and no `mem_we`. Drop `disp_req` → 4 consecutive `mem_we` cycles, addresses 10..13 in order.
- **Out of range:** push `wr_addr`=57600 → never written; `wr_err`=1 and stays set; the next valid write proceeds normally.
- **Full clear** (`IMAGE_MEM_CLEAR_EN`): `clear_start` with `disp_req` toggling 50% → every address 0..57599 written 0 exactly once; `clear_busy` high for 57600 + (display cycles) cycles; a queued FIFO write lands after the clear.
- **Reset mid-clear:** assert `reset` at clear pointer 1000 with 2 entries in the FIFO → next cycle `clear_busy`=0, `wr_ready`=1, no further `mem_we`.
